// File: rtl/gb_mmu.sv
// Memory-map unit: decodes CPU addresses and holds WRAM/HRAM.
// Also holds the boot-ROM overlay latch and runs the OAM DMA engine.
module gb_mmu #(
  parameter int WRAM_BITS = 13,
  parameter int DMA_LEN   = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_write,
  input  logic        cpu_do_write,
  output logic [7:0]  cpu_data_read,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  boot_addr,
  input  logic [7:0]  boot_data,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  input  logic [7:0]  oam_rdata,
  output logic [6:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  input  logic [7:0]  io_rdata,
  output logic        dma_active
);

  localparam int IW = $clog2(DMA_LEN + 1);

  typedef enum logic [3:0] {
    S_FF, S_ROM, S_BOOT, S_VRAM, S_WRAM,
    S_OAM, S_IO, S_HRAM, S_R46, S_R50
  } src_e;

  typedef enum logic [1:0] {IDLE, FILL, COPY} dma_e;

  function automatic src_e decode(
    input logic [15:0] a,
    input logic        ben
  );
    src_e s;
    if (!a[15])
      s = (ben && a[14:8] == 7'h00) ? S_BOOT : S_ROM;
    else if (a[14:13] == 2'b00) s = S_VRAM;
    else if (a[14:13] == 2'b01) s = S_FF;
    else if (a[14:13] == 2'b10) s = S_WRAM;
    else if (a < 16'hFE00) s = S_WRAM;
    else if (a < 16'hFEA0) s = S_OAM;
    else if (a < 16'hFF00) s = S_FF;
    else if (a == 16'hFF46) s = S_R46;
    else if (a == 16'hFF50) s = S_R50;
    else if (a < 16'hFF80 || a == 16'hFFFF) s = S_IO;
    else s = S_HRAM;
    return s;
  endfunction

  dma_e            state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [7:0]      src_hi, ff46_q;
  logic            boot_en;
  src_e            cpu_sel, sel_q, dma_sel, dma_sel_q;
  logic            dma_on, cpu_ok, dma_rd, dma_wr;
  logic [15:0]     dma_addr;
  logic [7:0]      dma_data, wram_q, hram_q;
  logic            wram_we, hram_we, ff46_we, ff50_we;
  logic [WRAM_BITS-1:0] wram_ra;

  logic [7:0] wram [0:(1<<WRAM_BITS)-1];
  logic [7:0] hram [0:127];

  assign dma_on     = state != IDLE;
  assign dma_active = dma_on;
  assign cpu_sel    = decode(cpu_addr, boot_en);
  assign cpu_ok     = !dma_on || cpu_sel == S_HRAM;
  assign dma_addr   = {src_hi, 8'(idx)};
  assign dma_sel    = decode(dma_addr, boot_en);

  // FF46 writes are honoured even mid-DMA so software can restart it
  assign ff46_we = cpu_do_write && cpu_sel == S_R46;
  assign ff50_we = cpu_do_write && cpu_ok && cpu_sel == S_R50;
  assign wram_we = cpu_do_write && cpu_ok && cpu_sel == S_WRAM;
  assign hram_we = cpu_do_write && cpu_ok && cpu_sel == S_HRAM;
  assign vram_we = cpu_do_write && cpu_ok && cpu_sel == S_VRAM;
  assign io_we   = cpu_do_write && cpu_ok && cpu_sel == S_IO;

  assign dma_wr = state == COPY && !reset;
  assign dma_rd = state == FILL ||
                  (state == COPY && idx != IW'(DMA_LEN));

  assign oam_we    = dma_wr ||
                     (cpu_do_write && cpu_ok && cpu_sel == S_OAM);
  assign oam_addr  = dma_on ? 8'(idx - IW'(1)) : cpu_addr[7:0];
  assign oam_wdata = dma_on ? dma_data : cpu_data_write;

  assign rom_addr   = dma_on ? dma_addr[14:0] : cpu_addr[14:0];
  assign boot_addr  = dma_on ? dma_addr[7:0] : cpu_addr[7:0];
  assign vram_addr  = dma_on ? dma_addr[12:0] : cpu_addr[12:0];
  assign wram_ra    = dma_on ? dma_addr[WRAM_BITS-1:0]
                             : cpu_addr[WRAM_BITS-1:0];
  assign vram_wdata = cpu_data_write;
  assign io_addr    = cpu_addr[6:0];
  assign io_wdata   = cpu_data_write;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: ;
      FILL: begin
        state_n = COPY;
        idx_n   = IW'(1);
      end
      COPY: begin
        if (idx == IW'(DMA_LEN)) state_n = IDLE;
        else idx_n = idx + IW'(1);
      end
      default: state_n = IDLE;
    endcase
    if (ff46_we) begin
      state_n = FILL;
      idx_n   = '0;
    end
  end

  always_comb begin
    dma_data = 8'hFF;
    unique case (dma_sel_q)
      S_ROM:   dma_data = rom_data;
      S_BOOT:  dma_data = boot_data;
      S_VRAM:  dma_data = vram_rdata;
      S_WRAM:  dma_data = wram_q;
      default: dma_data = 8'hFF;
    endcase
  end

  always_comb begin
    cpu_data_read = 8'hFF;
    unique case (sel_q)
      S_ROM:   cpu_data_read = rom_data;
      S_BOOT:  cpu_data_read = boot_data;
      S_VRAM:  cpu_data_read = vram_rdata;
      S_WRAM:  cpu_data_read = wram_q;
      S_OAM:   cpu_data_read = oam_rdata;
      S_IO:    cpu_data_read = io_rdata;
      S_HRAM:  cpu_data_read = hram_q;
      S_R46:   cpu_data_read = ff46_q;
      S_R50:   cpu_data_read = {7'h7F, ~boot_en};
      default: cpu_data_read = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      src_hi    <= 8'h00;
      ff46_q    <= 8'h00;
      boot_en   <= 1'b1;
      sel_q     <= S_FF;
      dma_sel_q <= S_FF;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sel_q <= cpu_ok ? cpu_sel : S_FF;
      if (dma_rd) dma_sel_q <= dma_sel;
      if (ff46_we) begin
        ff46_q <= cpu_data_write;
        src_hi <= (cpu_data_write >= 8'hE0)
                  ? cpu_data_write - 8'h20 : cpu_data_write;
      end
      if (ff50_we && cpu_data_write != 8'h00) boot_en <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wram_we) wram[cpu_addr[WRAM_BITS-1:0]] <= cpu_data_write;
    wram_q <= wram[wram_ra];
    if (hram_we) hram[cpu_addr[6:0]] <= cpu_data_write;
    hram_q <= hram[cpu_addr[6:0]];
  end

endmodule

// File: tb/tb_gb_mmu.sv
// Directed bench for gb_mmu: address map, overlay latch, OAM DMA.
// Memories around the MMU are modelled as 1-cycle synchronous blocks.
module tb_gb_mmu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_data_write = 8'h0;
  logic        cpu_do_write = 1'b0;
  logic [7:0]  cpu_data_read;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  boot_addr;
  logic [7:0]  boot_data;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata;
  logic [6:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic [7:0]  io_rdata;
  logic        dma_active;

  gb_mmu dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_write(cpu_data_write),
    .cpu_do_write(cpu_do_write), .cpu_data_read(cpu_data_read),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .boot_addr(boot_addr), .boot_data(boot_data),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .oam_we(oam_we), .oam_rdata(oam_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_rdata(io_rdata),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] vmem [0:8191];
  logic [7:0] omem [0:255];
  logic [7:0] olog_a [0:511];
  logic [7:0] olog_d [0:511];
  int ocnt = 0;

  always @(posedge clk) begin
    rom_data  <= (rom_addr == 15'h0150) ? 8'h31
                 : rom_addr[7:0] ^ 8'h96;
    boot_data <= boot_addr ^ 8'h5C;
    if (vram_we) vmem[vram_addr] <= vram_wdata;
    vram_rdata <= vmem[vram_addr];
    if (oam_we) omem[oam_addr] <= oam_wdata;
    oam_rdata <= omem[oam_addr];
    io_rdata  <= {1'b0, io_addr} ^ 8'hA0;
    if (oam_we && ocnt < 512) begin
      olog_a[ocnt] <= oam_addr;
      olog_d[ocnt] <= oam_wdata;
      ocnt <= ocnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic w,
                       input logic [7:0] d);
    cpu_addr = a;
    cpu_do_write = w;
    cpu_data_write = d;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic [2:0]  we;
    logic        rd;
    logic [7:0]  exp;
  } vec_t;

  vec_t v[$];

  initial begin
    int active;
    int base;
    int n0;

    v.push_back('{16'hC123, 1'b1, 8'h5A, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'hE123, 1'b0, 8'h00, 3'b000, 1'b1, 8'h5A});
    v.push_back('{16'hC123, 1'b0, 8'h00, 3'b000, 1'b1, 8'h5A});
    v.push_back('{16'hFD00, 1'b1, 8'h77, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'hDD00, 1'b0, 8'h00, 3'b000, 1'b1, 8'h77});
    v.push_back('{16'hFF80, 1'b1, 8'hA5, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'hFFFE, 1'b1, 8'hA5, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'hFF80, 1'b0, 8'h00, 3'b000, 1'b1, 8'hA5});
    v.push_back('{16'hFFFE, 1'b0, 8'h00, 3'b000, 1'b1, 8'hA5});
    v.push_back('{16'hFEA5, 1'b1, 8'h12, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'hFEA5, 1'b0, 8'h00, 3'b000, 1'b1, 8'hFF});
    v.push_back('{16'hA000, 1'b1, 8'h34, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'hA000, 1'b0, 8'h00, 3'b000, 1'b1, 8'hFF});
    v.push_back('{16'h0150, 1'b0, 8'h00, 3'b000, 1'b1, 8'h31});
    v.push_back('{16'h0010, 1'b0, 8'h00, 3'b000, 1'b1, 8'h4C});
    v.push_back('{16'hFF50, 1'b0, 8'h00, 3'b000, 1'b1, 8'hFE});
    v.push_back('{16'hFF50, 1'b1, 8'h01, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'h0010, 1'b0, 8'h00, 3'b000, 1'b1, 8'h86});
    v.push_back('{16'hFF50, 1'b0, 8'h00, 3'b000, 1'b1, 8'hFF});
    v.push_back('{16'hFF50, 1'b1, 8'h00, 3'b000, 1'b0, 8'h00});
    v.push_back('{16'h0010, 1'b0, 8'h00, 3'b000, 1'b1, 8'h86});
    v.push_back('{16'h8005, 1'b1, 8'h3C, 3'b100, 1'b0, 8'h00});
    v.push_back('{16'h8005, 1'b0, 8'h00, 3'b000, 1'b1, 8'h3C});
    v.push_back('{16'hFE10, 1'b1, 8'h9A, 3'b010, 1'b0, 8'h00});
    v.push_back('{16'hFE10, 1'b0, 8'h00, 3'b000, 1'b1, 8'h9A});
    v.push_back('{16'hFF05, 1'b1, 8'h11, 3'b001, 1'b0, 8'h00});
    v.push_back('{16'hFF05, 1'b0, 8'h00, 3'b000, 1'b1, 8'hA5});
    v.push_back('{16'hFFFF, 1'b1, 8'h1F, 3'b001, 1'b0, 8'h00});
    v.push_back('{16'hFFFF, 1'b0, 8'h00, 3'b000, 1'b1, 8'hDF});
    v.push_back('{16'hFF46, 1'b0, 8'h00, 3'b000, 1'b1, 8'h00});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rd", 16'(cpu_data_read), 16'hFF);
    chk("rst_dma", 16'(dma_active), 16'h0);
    chk("rst_we", 16'({vram_we, oam_we, io_we}), 16'h0);
    reset = 1'b0;

    // ROM address is combinational, data one clock later
    cpu_addr = 16'h0150;
    #1;
    chk("rom_addr", 16'(rom_addr), 16'h0150);
    @(negedge clk);
    chk("rom_rd", 16'(cpu_data_read), 16'h31);

    foreach (v[i]) begin
      cpu_addr = v[i].a;
      cpu_do_write = v[i].w;
      cpu_data_write = v[i].d;
      #1;
      chk($sformatf("we%0d", i),
          16'({vram_we, oam_we, io_we}), 16'(v[i].we));
      @(negedge clk);
      if (v[i].rd)
        chk($sformatf("rd%0d", i), 16'(cpu_data_read), 16'(v[i].exp));
    end

    // preload DMA sources
    for (int i = 0; i < 160; i++)
      drive(16'hC000 + 16'(i), 1'b1, 8'(i) ^ 8'h3C);
    drive(16'hC100, 1'b1, 8'hE7);

    // full DMA from C000 with concurrent CPU traffic
    base = ocnt;
    active = 0;
    drive(16'hFF46, 1'b1, 8'hC0);
    if (dma_active) active++;
    drive(16'hC000, 1'b0, 8'h00);
    chk("dma_wram_rd", 16'(cpu_data_read), 16'hFF);
    if (dma_active) active++;
    drive(16'hFF80, 1'b0, 8'h00);
    chk("dma_hram_rd", 16'(cpu_data_read), 16'hA5);
    if (dma_active) active++;
    for (int n = 0; n < 400 && dma_active; n++) begin
      drive(16'h0000, 1'b0, 8'h00);
      if (dma_active) active++;
    end
    chk("dma_done", 16'(dma_active), 16'h0);
    chk("dma_cycles", 16'(active), 16'd161);
    chk("dma_writes", 16'(ocnt - base), 16'd160);
    for (int j = 0; j < 160; j++) begin
      if (base + j < 512) begin
        chk($sformatf("oam_a%0d", j), 16'(olog_a[base + j]), 16'(j));
        chk($sformatf("oam_d%0d", j), 16'(olog_d[base + j]),
            16'(8'(j) ^ 8'h3C));
      end
    end
    drive(16'hFF46, 1'b0, 8'h00);
    chk("ff46_rd", 16'(cpu_data_read), 16'hC0);

    // echo source E1 -> C100, then reset mid-copy
    base = ocnt;
    drive(16'hFF46, 1'b1, 8'hE1);
    for (int n = 0; n < 50; n++) drive(16'hFF80, 1'b0, 8'h00);
    chk("echo_src_a", 16'(olog_a[base]), 16'h00);
    chk("echo_src_d", 16'(olog_d[base]), 16'hE7);
    chk("mid_dma", 16'(dma_active), 16'h1);
    reset = 1'b1;
    cpu_addr = 16'h0000;
    @(negedge clk);
    chk("rst_oam_we", 16'(oam_we), 16'h0);
    chk("rst_dma_act", 16'(dma_active), 16'h0);
    n0 = ocnt;
    reset = 1'b0;
    repeat (5) drive(16'h0000, 1'b0, 8'h00);
    chk("no_oam_after_rst", 16'(ocnt - n0), 16'h0);
    drive(16'hFF46, 1'b0, 8'h00);
    chk("ff46_after_rst", 16'(cpu_data_read), 16'h00);
    drive(16'h0010, 1'b0, 8'h00);
    chk("boot_after_rst", 16'(cpu_data_read), 16'h4C);
    drive(16'hFF50, 1'b0, 8'h00);
    chk("ff50_after_rst", 16'(cpu_data_read), 16'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
